// File: rtl/mem_seq_multicore_if.sv
// rtl/mem_seq_multicore_if.sv - control-unit handshake and per-core enable bus for the memory sequencer
interface mem_seq_multicore_if #(
  parameter int N_CORES = 4,
  parameter int NOC_W   = 16,
  parameter int IDX_W   = 4
);
  logic               start;
  logic [1:0]         mode;
  logic [NOC_W-1:0]   num_cores;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   cur_core;
  logic [N_CORES-1:0] ar_rd_en;
  logic [N_CORES-1:0] dr_wr_en;
  logic [N_CORES-1:0] d_rd_en;
  logic               dmem_wr;

  modport master (
    output start, mode, num_cores,
    input  busy, done, cur_core, ar_rd_en, dr_wr_en, d_rd_en, dmem_wr
  );

  modport slave (
    input  start, mode, num_cores,
    output busy, done, cur_core, ar_rd_en, dr_wr_en, d_rd_en, dmem_wr
  );
endinterface

// File: rtl/mem_seq_multicore.sv
// rtl/mem_seq_multicore.sv - broadcast/scatter/gather data-memory access sequencer for N cores
module mem_seq_multicore #(
  parameter int N_CORES = 4,
  parameter int RD_LAT  = 2,
  parameter int NOC_W   = 16,
  parameter int IDX_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_seq_multicore_if.slave    bus
);
  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT);

  typedef enum logic [2:0] {IDLE, BCAST, SCAT, GATH, FIN} state_t;

  state_t             state, state_n;
  logic [LAT_W-1:0]   lat, lat_n;
  logic [IDX_W-1:0]   core, core_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [NOC_W-1:0]   n_full;

  logic               busy_n, done_n, dmem_n;
  logic [IDX_W-1:0]   cur_n;
  logic [N_CORES-1:0] ar_n, dr_n, d_n;

  logic               busy_q, done_q, dmem_q;
  logic [IDX_W-1:0]   cur_q;
  logic [N_CORES-1:0] ar_q, dr_q, d_q;

  // Clamp on the full-width request so huge counts never alias to small ones
  assign n_full = (bus.num_cores > NOC_W'(N_CORES)) ? NOC_W'(N_CORES) : bus.num_cores;

  always_comb begin
    state_n = state;
    lat_n   = lat;
    core_n  = core;
    last_n  = last;
    case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        lat_n   = '0;
        core_n  = '0;
        if (bus.start) begin
          case (bus.mode)
            2'b01: state_n = BCAST;
            2'b10: begin
              state_n = (n_full == '0) ? FIN : SCAT;
              last_n  = IDX_W'(n_full - NOC_W'(1));
            end
            2'b11: begin
              state_n = (n_full == '0) ? FIN : GATH;
              last_n  = IDX_W'(n_full - NOC_W'(1));
            end
            default: state_n = IDLE;
          endcase
        end
      end
      BCAST: begin
        if (lat == LAT_MAX) begin
          lat_n   = '0;
          state_n = FIN;
        end else begin
          lat_n = lat + LAT_W'(1);
        end
      end
      SCAT: begin
        if (lat == LAT_MAX) begin
          lat_n = '0;
          if (core == last) begin
            core_n  = '0;
            state_n = FIN;
          end else begin
            core_n = core + IDX_W'(1);
          end
        end else begin
          lat_n = lat + LAT_W'(1);
        end
      end
      GATH: begin
        if (core == last) begin
          core_n  = '0;
          state_n = FIN;
        end else begin
          core_n = core + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers aligned with it
  always_comb begin
    busy_n = 1'b0;
    done_n = 1'b0;
    dmem_n = 1'b0;
    cur_n  = '0;
    ar_n   = '0;
    dr_n   = '0;
    d_n    = '0;
    case (state_n)
      BCAST: begin
        busy_n = 1'b1;
        ar_n   = N_CORES'(1);
        if (lat_n == LAT_MAX) dr_n = '1;
      end
      SCAT: begin
        busy_n = 1'b1;
        cur_n  = core_n;
        ar_n   = N_CORES'(1) << core_n;
        if (lat_n == LAT_MAX) dr_n = N_CORES'(1) << core_n;
      end
      GATH: begin
        busy_n = 1'b1;
        cur_n  = core_n;
        ar_n   = N_CORES'(1) << core_n;
        d_n    = N_CORES'(1) << core_n;
        dmem_n = 1'b1;
      end
      FIN:     done_n = 1'b1;
      default: done_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lat    <= '0;
      core   <= '0;
      last   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dmem_q <= 1'b0;
      cur_q  <= '0;
      ar_q   <= '0;
      dr_q   <= '0;
      d_q    <= '0;
    end else begin
      state  <= state_n;
      lat    <= lat_n;
      core   <= core_n;
      last   <= last_n;
      busy_q <= busy_n;
      done_q <= done_n;
      dmem_q <= dmem_n;
      cur_q  <= cur_n;
      ar_q   <= ar_n;
      dr_q   <= dr_n;
      d_q    <= d_n;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dmem_wr  = dmem_q;
  assign bus.cur_core = cur_q;
  assign bus.ar_rd_en = ar_q;
  assign bus.dr_wr_en = dr_q;
  assign bus.d_rd_en  = d_q;
endmodule

// File: doc/mem_seq_multicore.md
Name: mem_seq_multicore

Overview:
Parametrised data-memory access sequencer for the multi-core processor. It generates per-core register/memory enables for three transfer modes:
- broadcast: one address read, result written to all cores' DRs.
- scatter: each core reads its own AR and loads its own DR.
- gather: each core's D register is written to data memory through its AR.

It sits between the main control unit and the AR/DR/D register banks. Versus the fixed 4-core controller, it adds a core-count parameter, configurable read latency, a start/busy/done handshake, count clamping and synchronous reset.

Parameters:
N_CORES, 4, number of cores (1..16); width of every enable vector.
RD_LAT, 2, data-memory read latency in cycles; each read slot lasts RD_LAT+1 cycles.
NOC_W, 16, width of the num_cores input.
IDX_W, 4, width of cur_core; must satisfy 2^IDX_W >= N_CORES.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only when busy=0
mode  in  2  01=broadcast, 10=scatter, 11=gather, 00=no-op
num_cores  in  NOC_W  number of active cores for scatter/gather
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle completion pulse
cur_core  out  IDX_W  index of the core currently being served (0 in IDLE)
ar_rd_en  out  N_CORES  one-hot AR read enable; bit i = core i
dr_wr_en  out  N_CORES  DR write enable(s)
d_rd_en  out  N_CORES  one-hot D register read enable
dmem_wr  out  1  data-memory write strobe

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset.
- Output timing: all outputs are registered; there is no combinational path from inputs to outputs.
- Reset: on the edge with rst=1, go to IDLE; all enables=0, busy=0, done=0, cur_core=0. This applies from any state, including mid-transfer. An aborted transfer produces no done.

States and transitions:
- IDLE, BCAST, SCAT, GATH, FIN.
- IDLE: on a start=1 edge, latch mode and n = min(num_cores, N_CORES).
  - mode=00: ignored, stay IDLE.
  - n=0 with scatter/gather: go to FIN with no enables.
  - Otherwise, on the accepting edge T, go to BCAST, SCAT or GATH. busy=1 from cycle T+1.
- BCAST: runs RD_LAT+1 cycles.
  - ar_rd_en[0]=1 in every cycle.
  - dr_wr_en = all ones in the final cycle only.
  - Then go to FIN.
- SCAT: for core k = 0..n-1, a slot of RD_LAT+1 cycles.
  - ar_rd_en = one-hot(k) throughout the slot.
  - dr_wr_en = one-hot(k) in the slot's last cycle only.
  - cur_core = k.
  - After the last cycle of slot n-1, go to FIN.
- GATH: for core k = 0..n-1, one cycle each.
  - ar_rd_en = d_rd_en = one-hot(k), dmem_wr=1, cur_core = k.
  - After k = n-1, go to FIN.
- FIN: one cycle, done=1, busy=0, all enables 0, cur_core=0. Then go to IDLE.
  - A start present in the FIN cycle is accepted exactly as in IDLE (back-to-back).
- start while busy=1: ignored. mode/num_cores changes while busy: ignored, because values are latched at acceptance.

Counters and width rules:
- Latency counter runs 0..RD_LAT, then wraps to 0 at each slot end.
- Core counter is IDX_W bits and never exceeds n-1.
- Clamp comparison is on the full NOC_W value; no truncation before the compare.

Cycle totals from acceptance edge T:
- done at T + 1 + L, where L is:
  - broadcast: RD_LAT+1
  - scatter: n*(RD_LAT+1)
  - gather: n
  - n=0: 0
- No two bits of ar_rd_en or d_rd_en are ever set together.
- dr_wr_en is multi-hot only in the BCAST final cycle.

Test Plan:
All scenarios use N_CORES=4, RD_LAT=2, start at edge 0.
1. Broadcast, mode=01 -> cycles 1-3: ar_rd_en=0001, busy=1. Cycle 3: dr_wr_en=1111. Cycle 4: done=1, busy=0. d_rd_en and dmem_wr are 0 throughout.
2. Scatter, mode=10, num_cores=3 -> ar_rd_en=0001 in cycles 1-3, 0010 in 4-6, 0100 in 7-9. dr_wr_en matches one-hot only in cycles 3, 6, 9. cur_core=0,1,2 per slot. done in cycle 10.
3. Gather, mode=11, num_cores=4 -> cycles 1-4: ar_rd_en=d_rd_en=0001, 0010, 0100, 1000, dmem_wr=1. Cycle 5: done=1, all enables 0.
4. Count boundaries:
   - num_cores=0, gather -> done in cycle 1, no enable ever high.
   - num_cores=16'hFFFF, gather -> clamped to 4, done in cycle 5.
5. Reset mid-scatter (num_cores=4): rst=1 at edge 5 -> cycle 6 all outputs 0, busy=0, no done. Then start broadcast at edge 7 -> done in cycle 11.
6. Handshake rules:
   - start with mode=00 -> no response.
   - start during an active gather -> ignored, original done timing unchanged.
   - start in the FIN cycle (cycle 5 of a 4-core gather) -> new transfer enables begin in cycle 6.
